branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Consumer of the ALU flag outputs (Z, N, V, C). Resolves RV32 conditional branches from the flags of the ALU SUB that compares rs1 and rs2.
- Sits between decode/issue and fetch. Accepts one branch at a time over a valid/ready handshake and waits for the flags.
- Emits a registered resolve result and a redirect target, then holds a flush window so fetch squashes wrong-path instructions.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush stays high after a taken branch; legal range 1..15.
- TIMEOUT, 8, max cycles spent in WAIT before abort; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- br_valid  input  1  branch request valid
- br_ready  output  1  request accepted when br_valid & br_ready
- br_funct3  input  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- br_pc  input  32  PC of the branch
- br_imm  input  32  sign-extended branch offset
- flags_valid  input  1  ALU flags valid this cycle
- flag_z, flag_n, flag_v, flag_c  input  1 each  ALU flags of rs1 - rs2
- resolve_valid  output  1  one-cycle pulse, result valid
- taken  output  1  branch decision, meaningful when resolve_valid
- redirect  output  1  pulse equal to resolve_valid & taken
- target  output  32  br_pc + br_imm, mod 2^32
- flush  output  1  high during FLUSH state
- err  output  1  one-cycle pulse: illegal funct3 or timeout

Behaviour:
- Single clock. Reset is synchronous and active-high: rst sampled high at a rising edge of clk forces reset.
- Reset values: state IDLE, br_ready=1, resolve_valid=0, taken=0, redirect=0, target=0, flush=0, err=0, timeout counter=0, flush counter=0.
- Reset has priority over all events, including mid-WAIT and mid-FLUSH. flush drops at the reset edge.
- Carry convention: C = carry-out of rs1 + ~rs2 + 1, so C=1 means rs1 >= rs2 unsigned.
- Conditions:
  - BEQ: Z
  - BNE: !Z
  - BLT: N^V
  - BGE: !(N^V)
  - BLTU: !C
  - BGEU: C
- States:
  - IDLE: br_ready=1. On br_valid, latch funct3, pc and imm, and compute target = pc + imm (32-bit wrap, no overflow flag). Go to WAIT and clear the timeout counter. flags_valid is ignored in IDLE.
  - WAIT: br_ready=0; the timeout counter increments each cycle.
    - On flags_valid with legal funct3: register taken, assert resolve_valid (and redirect if taken) for exactly one cycle after the flags_valid edge. Go to FLUSH if taken, otherwise IDLE.
    - On flags_valid with illegal funct3 (010, 011): resolve_valid=1, taken=0, err=1 for one cycle, then IDLE.
    - If the counter reaches TIMEOUT with no flags_valid: err=1 for one cycle, resolve_valid=0, then IDLE.
    - flags_valid in the same cycle the counter reaches TIMEOUT: flags win, no err.
  - FLUSH: br_ready=0, flush=1. Counter runs FLUSH_CYCLES cycles, then IDLE. flush is high exactly FLUSH_CYCLES cycles, starting the same cycle as redirect.
- Latency: accept edge to resolve_valid = 1 cycle plus the wait for flags_valid. Minimum accept-to-resolve is 2 edges (flags_valid asserted the first cycle in WAIT).
- Back-to-back: after not-taken, br_ready is high in the cycle following resolve_valid. After taken, br_ready returns the cycle after flush falls.
- target holds its value until the next accept. Other pulses are low outside their single cycle.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs stat_total [31:0], stat_taken [31:0] and stat_err [15:0].
  - Each counter increments on resolve_valid, redirect and err respectively.
  - All counters wrap at max and clear on rst.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- BEQ taken:
  - Stimulus: pc=0x100, imm=0x20, Z=1, flags_valid one cycle after accept.
  - Response: resolve_valid=1, taken=1, redirect=1, target=0x120; flush high 2 cycles; br_ready back high after that.
- BLT vs BLTU with the same flags (N=1, V=0, C=1, i.e. -1 vs 1):
  - BLT: taken=1.
  - BLTU: taken=0, no redirect, no flush, br_ready high next cycle.
- Target wrap and illegal funct3:
  - pc=0xFFFFFFF0, imm=0x20 -> target=0x00000010.
  - funct3=010 with flags_valid -> err=1, taken=0, return to IDLE.
- Timeout:
  - Accept, never assert flags_valid -> err pulses after 8 WAIT cycles, resolve_valid stays 0.
  - flags_valid asserted on the 8th cycle instead -> normal resolve, no err.
- Reset mid-FLUSH:
  - rst high in the 1st flush cycle -> next edge flush=0, br_ready=1, all outputs at reset values.
  - A stale flags_valid after reset is ignored.
- Handshake spacing:
  - br_valid held high continuously with alternating BEQ taken / BNE not-taken -> exactly one accept per resolve+flush window.
  - No accept while br_ready=0.
  - With BRANCH_STATS_EN: stat_total and stat_taken match the counts.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Branch request, ALU flag and resolve/redirect signals between issue, ALU and fetch.
// master: issue/ALU side; slave: the resolver.
interface branch_resolver_if;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_funct3;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        flags_valid;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;
    logic        flag_c;
    logic        resolve_valid;
    logic        taken;
    logic        redirect;
    logic [31:0] target;
    logic        flush;
    logic        err;

    modport master (
        output br_valid, br_funct3, br_pc, br_imm,
        output flags_valid, flag_z, flag_n, flag_v, flag_c,
        input  br_ready, resolve_valid, taken, redirect, target, flush, err
    );

    modport slave (
        input  br_valid, br_funct3, br_pc, br_imm,
        input  flags_valid, flag_z, flag_n, flag_v, flag_c,
        output br_ready, resolve_valid, taken, redirect, target, flush, err
    );
endinterface

// File: rtl/branch_resolver.sv
// Resolves RV32 conditional branches from ALU SUB flags, then holds a fetch flush window.
// Optional macro BRANCH_STATS_EN adds resolve/taken/err event counters.
module branch_resolver #(
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 8
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolver_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      stat_total,
    output logic [31:0]      stat_taken,
    output logic [15:0]      stat_err
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] FLUSH_LAST   = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [7:0]  tcnt_q;
    logic [3:0]  fcnt_q;
    logic        accept;
    logic        rv_d;
    logic        taken_d;
    logic        err_d;
    logic        flush_d;

    function automatic logic funct3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    // C is the carry-out of rs1 + ~rs2 + 1, so C=1 means rs1 >= rs2 unsigned.
    function automatic logic branch_cond(input logic [2:0] f3, input logic z, input logic n,
                                         input logic v, input logic c);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n ^ v;
            3'b101:  return !(n ^ v);
            3'b110:  return !c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    assign bus.br_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rv_d    = 1'b0;
        taken_d = 1'b0;
        err_d   = 1'b0;
        flush_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.br_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Flags arriving on the last allowed cycle still win over the timeout.
                if (bus.flags_valid) begin
                    rv_d = 1'b1;
                    if (funct3_legal(funct3_q)) begin
                        taken_d = branch_cond(funct3_q, bus.flag_z, bus.flag_n,
                                              bus.flag_v, bus.flag_c);
                        flush_d = taken_d;
                        state_d = taken_d ? FLUSH : IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (tcnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (fcnt_q == FLUSH_LAST) state_d = IDLE;
                else                      flush_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            tcnt_q            <= 8'd0;
            fcnt_q            <= 4'd0;
            funct3_q          <= 3'd0;
            bus.resolve_valid <= 1'b0;
            bus.taken         <= 1'b0;
            bus.redirect      <= 1'b0;
            bus.err           <= 1'b0;
            bus.flush         <= 1'b0;
            bus.target        <= 32'd0;
        end else begin
            state_q           <= state_d;
            bus.resolve_valid <= rv_d;
            bus.taken         <= taken_d;
            bus.redirect      <= rv_d & taken_d;
            bus.err           <= err_d;
            bus.flush         <= flush_d;
            tcnt_q            <= (state_q == WAIT)  ? tcnt_q + 8'd1 : 8'd0;
            fcnt_q            <= (state_q == FLUSH) ? fcnt_q + 4'd1 : 4'd0;
            if (accept) begin
                funct3_q   <= bus.br_funct3;
                bus.target <= bus.br_pc + bus.br_imm;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total <= 32'd0;
            stat_taken <= 32'd0;
            stat_err   <= 16'd0;
        end else begin
            if (bus.resolve_valid) stat_total <= stat_total + 32'd1;
            if (bus.redirect)      stat_taken <= stat_taken + 32'd1;
            if (bus.err)           stat_err   <= stat_err + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: expected results are queued at issue and
// compared when the resolver reports resolve_valid or err.
module tb_branch_resolver;
    localparam int FLUSH_CYCLES = 2;
    localparam int TIMEOUT      = 8;

    logic clk = 1'b0;
    logic rst;

    branch_resolver_if bus();

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_total;
    logic [31:0] stat_taken;
    logic [15:0] stat_err;
`endif

    branch_resolver #(.FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BRANCH_STATS_EN
        ,
        .stat_total(stat_total),
        .stat_taken(stat_taken),
        .stat_err(stat_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rv;
        logic        tk;
        logic        er;
        logic [31:0] tg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   n_total = 0;
    int   n_taken = 0;
    int   n_err   = 0;

    // Flags of rs1 - rs2 as the ALU would produce them: {Z, N, V, C}
    function automatic logic [3:0] sub_flags(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] d;
        d = {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {d[31:0] == 32'd0, d[31], (a[31] != b[31]) && (d[31] != a[31]), d[32]};
    endfunction

    // Expected outcome from a direct comparison of the operands
    function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm);
        exp_t e;
        e.rv = 1'b1;
        e.er = 1'b0;
        e.tg = pc + imm;
        case (f3)
            3'b000:  e.tk = (a == b);
            3'b001:  e.tk = (a != b);
            3'b100:  e.tk = ($signed(a) <  $signed(b));
            3'b101:  e.tk = ($signed(a) >= $signed(b));
            3'b110:  e.tk = (a <  b);
            3'b111:  e.tk = (a >= b);
            default: begin e.tk = 1'b0; e.er = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic push_exp(input exp_t e);
        sb.push_back(e);
        if (e.rv)         n_total++;
        if (e.rv && e.tk) n_taken++;
        if (e.er)         n_err++;
    endtask

    always @(negedge clk) begin
        if (bus.resolve_valid === 1'b1 || bus.err === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: resolve_valid=%b err=%b with no pending branch",
                         bus.resolve_valid, bus.err);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.resolve_valid, bus.taken, bus.redirect, bus.err, bus.target} !==
                    {mon_e.rv, mon_e.tk, mon_e.rv & mon_e.tk, mon_e.er, mon_e.tg}) begin
                    errors++;
                    $display("FAIL sb_result: got rv=%b taken=%b redirect=%b err=%b target=%h, want rv=%b taken=%b redirect=%b err=%b target=%h",
                             bus.resolve_valid, bus.taken, bus.redirect, bus.err, bus.target,
                             mon_e.rv, mon_e.tk, mon_e.rv & mon_e.tk, mon_e.er, mon_e.tg);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.br_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.br_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: br_ready=%b after %0d cycles, want 1", bus.br_ready, n);
        end
    endtask

    // Accept one branch, then present flags after dly extra WAIT cycles; returns 1 time unit
    // into the cycle in which the result is visible.
    task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input int dly);
        wait_ready();
        push_exp(model(f3, a, b, pc, imm));
        bus.br_valid  = 1'b1;
        bus.br_funct3 = f3;
        bus.br_pc     = pc;
        bus.br_imm    = imm;
        @(posedge clk); #1;
        bus.br_valid = 1'b0;
        repeat (dly) begin @(posedge clk); #1; end
        {bus.flag_z, bus.flag_n, bus.flag_v, bus.flag_c} = sub_flags(a, b);
        bus.flags_valid = 1'b1;
        @(posedge clk); #1;
        bus.flags_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.br_valid = 1'b0; bus.br_funct3 = 3'd0; bus.br_pc = 32'd0; bus.br_imm = 32'd0;
        bus.flags_valid = 1'b0;
        {bus.flag_z, bus.flag_n, bus.flag_v, bus.flag_c} = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.br_ready !== 1'b1)      begin errors++; $display("FAIL reset_br_ready: got %b want 1", bus.br_ready); end
        checks++; if (bus.resolve_valid !== 1'b0) begin errors++; $display("FAIL reset_resolve_valid: got %b want 0", bus.resolve_valid); end
        checks++; if (bus.taken !== 1'b0)         begin errors++; $display("FAIL reset_taken: got %b want 0", bus.taken); end
        checks++; if (bus.redirect !== 1'b0)      begin errors++; $display("FAIL reset_redirect: got %b want 0", bus.redirect); end
        checks++; if (bus.flush !== 1'b0)         begin errors++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
        checks++; if (bus.err !== 1'b0)           begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
        checks++; if (bus.target !== 32'd0)       begin errors++; $display("FAIL reset_target: got %h want 0", bus.target); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_beq_taken();
        int nflush = 0;
        issue(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0);
        checks++;
        if ({bus.resolve_valid, bus.redirect, bus.flush} !== 3'b111) begin
            errors++;
            $display("FAIL beq_min_latency: rv/redirect/flush=%b want 111", {bus.resolve_valid, bus.redirect, bus.flush});
        end
        checks++; if (bus.target !== 32'h120) begin errors++; $display("FAIL beq_target: got %h want 00000120", bus.target); end
        while (bus.flush === 1'b1 && nflush < 20) begin
            nflush++;
            @(posedge clk); #1;
        end
        checks++; if (nflush != FLUSH_CYCLES) begin errors++; $display("FAIL beq_flush_len: got %0d want %0d", nflush, FLUSH_CYCLES); end
        checks++; if (bus.br_ready !== 1'b1)  begin errors++; $display("FAIL beq_ready_after_flush: got %b want 1", bus.br_ready); end
    endtask

    task automatic test_blt_bltu();
        issue(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
        checks++;
        if ({bus.taken, bus.flush} !== 2'b11) begin
            errors++; $display("FAIL blt_taken: taken/flush=%b want 11", {bus.taken, bus.flush});
        end
        issue(3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
        checks++;
        if ({bus.resolve_valid, bus.taken, bus.redirect, bus.flush} !== 4'b1000) begin
            errors++; $display("FAIL bltu_not_taken: rv/taken/redirect/flush=%b want 1000",
                               {bus.resolve_valid, bus.taken, bus.redirect, bus.flush});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.br_ready, bus.flush} !== 2'b10) begin
            errors++; $display("FAIL bltu_ready_next: br_ready/flush=%b want 10", {bus.br_ready, bus.flush});
        end
    endtask

    task automatic test_wrap_illegal();
        issue(3'b001, 32'hFFFF_FFF0, 32'h20, 32'd1, 32'd2, 0);
        checks++; if (bus.target !== 32'h10) begin errors++; $display("FAIL wrap_target: got %h want 00000010", bus.target); end
        issue(3'b010, 32'h400, 32'h8, 32'd3, 32'd3, 1);
        checks++;
        if ({bus.resolve_valid, bus.taken, bus.err} !== 3'b101) begin
            errors++; $display("FAIL illegal_funct3: rv/taken/err=%b want 101", {bus.resolve_valid, bus.taken, bus.err});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.br_ready, bus.err, bus.flush} !== 3'b100) begin
            errors++; $display("FAIL illegal_idle: br_ready/err/flush=%b want 100", {bus.br_ready, bus.err, bus.flush});
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   k    = 0;
        logic seen = 1'b0;
        logic rv_seen = 1'b0;
        wait_ready();
        e.rv = 1'b0; e.tk = 1'b0; e.er = 1'b1; e.tg = 32'h510;
        push_exp(e);
        bus.br_valid = 1'b1; bus.br_funct3 = 3'b000; bus.br_pc = 32'h500; bus.br_imm = 32'h10;
        @(posedge clk); #1;
        bus.br_valid = 1'b0;
        while (!seen && k < TIMEOUT + 5) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (bus.resolve_valid === 1'b1) rv_seen = 1'b1;
            if (bus.err === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || k != TIMEOUT) begin errors++; $display("FAIL timeout_latency: err after %0d cycles (seen=%b) want %0d", k, seen, TIMEOUT); end
        checks++; if (rv_seen !== 1'b0)      begin errors++; $display("FAIL timeout_no_resolve: resolve_valid seen=%b want 0", rv_seen); end
        @(posedge clk); #1;
        issue(3'b000, 32'h600, 32'h4, 32'd7, 32'd7, TIMEOUT - 1);
        checks++;
        if ({bus.resolve_valid, bus.err} !== 2'b10) begin
            errors++; $display("FAIL timeout_flags_win: rv/err=%b want 10", {bus.resolve_valid, bus.err});
        end
    endtask

    task automatic test_reset_flush();
        issue(3'b000, 32'h700, 32'h40, 32'd9, 32'd9, 0);
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL rst_flush_pre: flush=%b want 1", bus.flush); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_total = 0; n_taken = 0; n_err = 0;
        checks++;
        if ({bus.br_ready, bus.resolve_valid, bus.taken, bus.redirect, bus.flush, bus.err} !== 6'b100000 ||
            bus.target !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_flush: ready/rv/taken/redirect/flush/err=%b target=%h want 100000 target=0",
                     {bus.br_ready, bus.resolve_valid, bus.taken, bus.redirect, bus.flush, bus.err}, bus.target);
        end
        rst = 1'b0;
        {bus.flag_z, bus.flag_n, bus.flag_v, bus.flag_c} = 4'b1001;
        bus.flags_valid = 1'b1;
        @(posedge clk); #1;
        bus.flags_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.resolve_valid, bus.err, bus.br_ready, bus.flush} !== 4'b0010) begin
                errors++; $display("FAIL stale_flags_%0d: rv/err/ready/flush=%b want 0010", i,
                                   {bus.resolve_valid, bus.err, bus.br_ready, bus.flush});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        int   idx     = 0;
        int   last_cyc = 0;
        int   gap;
        int   exp_gap;
        logic prev_tk = 1'b0;
        logic acc;
        logic [31:0] opnd;
        wait_ready();
        bus.br_valid  = 1'b1;
        bus.br_funct3 = 3'b000;
        bus.br_pc     = 32'h1000;
        bus.br_imm    = 32'h80;
        for (int cyc = 0; cyc < 200 && idx < N; cyc++) begin
            @(negedge clk);
            acc = (bus.br_ready === 1'b1) && bus.br_valid;
            @(posedge clk); #1;
            bus.flags_valid = 1'b0;
            if (acc) begin
                if (idx > 0) begin
                    gap     = cyc - last_cyc;
                    exp_gap = prev_tk ? 2 + FLUSH_CYCLES : 2;
                    checks++;
                    if (gap != exp_gap) begin
                        errors++; $display("FAIL b2b_spacing_%0d: accept gap %0d want %0d", idx, gap, exp_gap);
                    end
                end
                opnd = 32'(idx + 1);
                push_exp(model(bus.br_funct3, opnd, opnd, bus.br_pc, bus.br_imm));
                {bus.flag_z, bus.flag_n, bus.flag_v, bus.flag_c} = sub_flags(opnd, opnd);
                bus.flags_valid = 1'b1;
                prev_tk  = (bus.br_funct3 == 3'b000);
                last_cyc = cyc;
                idx++;
                if (idx < N) begin
                    bus.br_funct3 = (idx % 2 == 1) ? 3'b001 : 3'b000;
                    bus.br_pc     = 32'h1000 + 32'(idx * 'h40);
                end else begin
                    bus.br_valid = 1'b0;
                end
            end
        end
        bus.br_valid = 1'b0;
        @(posedge clk); #1;
        bus.flags_valid = 1'b0;
        checks++; if (idx != N) begin errors++; $display("FAIL b2b_accepts: got %0d want %0d", idx, N); end
        repeat (FLUSH_CYCLES + 4) begin @(posedge clk); #1; end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        checks++; if (stat_total !== 32'(n_total)) begin errors++; $display("FAIL stat_total: got %0d want %0d", stat_total, n_total); end
        checks++; if (stat_taken !== 32'(n_taken)) begin errors++; $display("FAIL stat_taken: got %0d want %0d", stat_taken, n_taken); end
        checks++; if (stat_err !== 16'(n_err))     begin errors++; $display("FAIL stat_err: got %0d want %0d", stat_err, n_err); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_beq_taken();
        test_blt_bltu();
        test_wrap_illegal();
        test_timeout();
        test_reset_flush();
        test_back_to_back();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d results never produced, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
